// File: rtl/vga_sync_tracker.sv
// -----------------------------------------------------------------------------
// vga_sync_tracker
//   Recovers the pixel/line position of a VGA-style raster from its hsync and
//   vsync pulses. It measures the line period and the frame length, checks them
//   against the nominal timing, and reports when it has locked to the source.
//
// Ports
//   clk        in   pixel clock; all state updates on its rising edge
//   rst_n      in   synchronous active-low reset
//   hsync_in   in   active-high horizontal sync
//   vsync_in   in   active-high vertical sync
//   px         out  [9:0] recovered horizontal position (0..H_TOTAL-1)
//   py         out  [8:0] low 9 bits of the recovered line number
//   visible    out  locked and inside the active area
//   locked     out  tracker is in LOCKED (registered)
//   line_err   out  one-cycle pulse after an hsync edge with a bad line period
//   frame_err  out  one-cycle pulse after a vsync edge with a bad frame length
// -----------------------------------------------------------------------------
module vga_sync_tracker #(
   parameter int H_DISPLAY    = 640,
   parameter int H_SYNC_START = 656,
   parameter int H_TOTAL      = 800,
   parameter int V_DISPLAY    = 480,
   parameter int V_SYNC_START = 490,
   parameter int V_TOTAL      = 525
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       hsync_in,
   input  logic       vsync_in,
   output logic [9:0] px,
   output logic [8:0] py,
   output logic       visible,
   output logic       locked,
   output logic       line_err,
   output logic       frame_err
);

   // The hsync edge is seen one cycle after the source passed H_SYNC_START,
   // so the counter is reloaded with the position the source has reached.
   localparam logic [9:0] LP_H_LOAD = 10'(H_SYNC_START + 1);
   localparam logic [9:0] LP_H_LAST = 10'(H_TOTAL - 1);
   localparam logic [9:0] LP_H_TOT  = 10'(H_TOTAL);
   localparam logic [9:0] LP_H_DISP = 10'(H_DISPLAY);
   localparam logic [9:0] LP_V_LOAD = 10'(V_SYNC_START);
   localparam logic [9:0] LP_V_LAST = 10'(V_TOTAL - 1);
   localparam logic [9:0] LP_V_TOT  = 10'(V_TOTAL);
   localparam logic [9:0] LP_V_DISP = 10'(V_DISPLAY);
   localparam logic [9:0] LP_SAT    = 10'd1023;

   typedef enum logic [1:0] {
      S_SEARCH = 2'd0,
      S_H_LOCK = 2'd1,
      S_LOCKED = 2'd2
   } state_t;

   state_t     r_state;
   state_t     w_state_nxt;

   logic       r_hsync_d;
   logic       r_vsync_d;
   logic       r_hseen;
   logic       r_vseen;
   logic [9:0] r_hcnt;
   logic [9:0] r_vcnt;
   logic [9:0] r_hper;
   logic [9:0] r_vper;
   logic       r_locked;
   logic       r_line_err;
   logic       r_frame_err;

   logic       w_hrise;
   logic       w_vrise;
   logic       w_hwrap;
   logic       w_line_bad;
   logic       w_frame_bad;
   logic       w_timeout;
   logic       w_enter_search;
   logic       w_line_err_nxt;
   logic       w_frame_err_nxt;

   // ---------------------------------------------------------------- edges
   assign w_hrise     = hsync_in & ~r_hsync_d;
   assign w_vrise     = vsync_in & ~r_vsync_d;
   // End-of-line wrap; a reload on hrise takes priority and suppresses it.
   assign w_hwrap     = ~w_hrise & (r_hcnt >= LP_H_LAST);
   // Period checks use the pre-update measurement values.
   assign w_line_bad  = w_hrise & (r_hper != LP_H_TOT);
   assign w_frame_bad = w_vrise & (r_vper != LP_V_TOT);
   // hsync missing long enough for the period counter to saturate.
   assign w_timeout   = (r_hper == LP_SAT);

   // --------------------------------------------------------- next state
   always_comb begin
      w_state_nxt     = r_state;
      w_line_err_nxt  = 1'b0;
      w_frame_err_nxt = 1'b0;
      case (r_state)
         S_SEARCH: begin
            // Need one hrise to start a measurement, then a good period.
            if (w_hrise && r_hseen && (r_hper == LP_H_TOT))
               w_state_nxt = S_H_LOCK;
         end
         S_H_LOCK: begin
            w_line_err_nxt = w_line_bad;
            if (w_line_bad)
               w_state_nxt = S_SEARCH;
            else if (w_vrise && r_vseen && !w_frame_bad)
               w_state_nxt = S_LOCKED;
         end
         S_LOCKED: begin
            w_line_err_nxt  = w_line_bad;
            w_frame_err_nxt = w_frame_bad;
            if (w_line_bad || w_frame_bad)
               w_state_nxt = S_SEARCH;
         end
         default: w_state_nxt = S_SEARCH;
      endcase
      if (w_timeout)
         w_state_nxt = S_SEARCH;
   end

   assign w_enter_search = (w_state_nxt == S_SEARCH) && (r_state != S_SEARCH);

   // ------------------------------------------------------ sequential state
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state     <= S_SEARCH;
         r_hsync_d   <= 1'b0;
         r_vsync_d   <= 1'b0;
         r_hseen     <= 1'b0;
         r_vseen     <= 1'b0;
         r_hcnt      <= '0;
         r_vcnt      <= '0;
         r_hper      <= '0;
         r_vper      <= '0;
         r_locked    <= 1'b0;
         r_line_err  <= 1'b0;
         r_frame_err <= 1'b0;
      end else begin
         r_state     <= w_state_nxt;
         r_hsync_d   <= hsync_in;
         r_vsync_d   <= vsync_in;
         r_locked    <= (w_state_nxt == S_LOCKED);
         r_line_err  <= w_line_err_nxt;
         r_frame_err <= w_frame_err_nxt;

         // Position counters run in every state.
         if (w_hrise)
            r_hcnt <= LP_H_LOAD;
         else if (w_hwrap)
            r_hcnt <= '0;
         else
            r_hcnt <= r_hcnt + 10'd1;

         if (w_vrise)
            r_vcnt <= LP_V_LOAD;
         else if (w_hwrap)
            r_vcnt <= (r_vcnt >= LP_V_LAST) ? '0 : r_vcnt + 10'd1;

         // Clocks since the last hrise, saturating.
         if (w_hrise)
            r_hper <= 10'd1;
         else if (r_hper != LP_SAT)
            r_hper <= r_hper + 10'd1;

         // hrises since the last vrise; a coincident hrise counts as the first.
         if (w_vrise)
            r_vper <= {9'd0, w_hrise};
         else if (w_hrise && (r_vper != LP_SAT))
            r_vper <= r_vper + 10'd1;

         if (w_enter_search)
            r_hseen <= 1'b0;
         else if (w_hrise)
            r_hseen <= 1'b1;

         // vsync edges only count once horizontal lock has been reached.
         if (w_enter_search)
            r_vseen <= 1'b0;
         else if (w_vrise && (r_state != S_SEARCH))
            r_vseen <= 1'b1;
      end
   end

   // -------------------------------------------------------------- outputs
   assign px        = r_hcnt;
   assign py        = r_vcnt[8:0];
   assign visible   = r_locked & (r_hcnt < LP_H_DISP) & (r_vcnt < LP_V_DISP);
   assign locked    = r_locked;
   assign line_err  = r_line_err;
   assign frame_err = r_frame_err;

endmodule

// File: doc/vga_sync_tracker.md
VGA_SYNC_TRACKER -- requirements
Module: vga_sync_tracker

Interface
REQ-001 Parameter H_DISPLAY, 640: visible pixels per line.
REQ-002 Parameter H_SYNC_START, 656: horizontal position labelled on the hsync rising-edge cycle.
REQ-003 Parameter H_TOTAL, 800: clocks per line.
REQ-004 Parameter V_DISPLAY, 480: visible lines per frame.
REQ-005 Parameter V_SYNC_START, 490: line labelled on the vsync rising-edge cycle.
REQ-006 Parameter V_TOTAL, 525: lines per frame.
REQ-007 clk  input  1  pixel clock; the only clock; all state SHALL update on its rising edge.
REQ-008 rst_n  input  1  reset, synchronous, active-low.
REQ-009 hsync_in  input  1  active-high horizontal sync from the timing source.
REQ-010 vsync_in  input  1  active-high vertical sync from the timing source.
REQ-011 px  output  10  recovered horizontal position, 0..H_TOTAL-1.
REQ-012 py  output  9  recovered vertical position, low 9 bits of the internal 10-bit line counter.
REQ-013 visible  output  1  high iff locked and px<H_DISPLAY and line counter<V_DISPLAY.
REQ-014 locked  output  1  high in state LOCKED.
REQ-015 line_err  output  1  one-cycle pulse on a bad line period.
REQ-016 frame_err  output  1  one-cycle pulse on a bad frame length.

Function
REQ-017 Edge detect: hrise = hsync_in & ~hsync_d; vrise = vsync_in & ~vsync_d; hsync_d/vsync_d are 1-cycle delayed copies of the inputs.
REQ-018 Position counter hcnt (10 bit): on hrise load H_SYNC_START+1; otherwise at H_TOTAL-1 wrap to 0; otherwise increment. px = hcnt.
REQ-019 Line counter vcnt (10 bit): on vrise load V_SYNC_START (priority over wrap); otherwise when hcnt wraps to 0, wrap at V_TOTAL-1 to 0, else increment.
REQ-020 Line period hper (10 bit): on hrise load 1; otherwise increment, saturating at 1023; on hrise the pre-update value is the measured period.
REQ-021 Frame length vper (10 bit): on vrise load 1 if hrise in same cycle, else 0; otherwise increment on hrise, saturating at 1023.
REQ-022 Flags hseen (hrise occurred since entering SEARCH) and vseen (vrise occurred since entering H_LOCK) SHALL be cleared on every entry to SEARCH.
REQ-023 States SEARCH, H_LOCK, LOCKED (2-bit encoding).
REQ-024 SEARCH -> H_LOCK on hrise with hseen=1 and hper==H_TOTAL.
REQ-025 H_LOCK -> SEARCH on hrise with hper!=H_TOTAL; H_LOCK -> LOCKED on vrise with vseen=1 and vper==V_TOTAL; vrise with vper!=V_TOTAL stays in H_LOCK.
REQ-026 LOCKED -> SEARCH on line mismatch or frame mismatch; no other exit except timeout/reset.
REQ-027 Timeout: hper reaching 1023 in any state SHALL force SEARCH next cycle.
REQ-028 line_err SHALL pulse for the hrise cycle's following cycle when hper!=H_TOTAL in H_LOCK or LOCKED; never in SEARCH.
REQ-029 frame_err SHALL pulse the cycle after a vrise with vper!=V_TOTAL in LOCKED only.
REQ-030 locked, line_err, frame_err SHALL be registered; locked falls in the same cycle errors pulse.
REQ-031 hcnt/vcnt track in every state; only visible and locked are gated by state.
REQ-032 Simultaneous hrise and vrise: both counters reload per REQ-018/019; both checks evaluated in that cycle.
REQ-033 Fed from an upstream timing generator with registered syncs, px/py at cycle t SHALL equal the generator's position at t-1 once locked.

Reset
REQ-034 While rst_n=0 at a clock edge: state SEARCH; hcnt, vcnt, hper, vper = 0; hseen, vseen, hsync_d, vsync_d = 0; locked, line_err, frame_err = 0; hence visible=0.
REQ-035 A sync input already high at reset release SHALL be treated as a rising edge in the first cycle.
REQ-036 Reset mid-LOCKED SHALL take effect at the next edge with no error pulse.

Verification
REQ-037 rst_n low 3 cycles with toggling syncs -> px=0, py=0, visible=0, locked=0, no error pulses.
REQ-038 Driven by the 640x480 timing generator from reset -> locked rises at the second vrise (within ~2 frames, ≤840000 cycles); afterwards px/py/visible equal generator values delayed 1 cycle for 3 frames, zero error pulses.
REQ-039 While locked, one line shortened to 799 clocks -> line_err high exactly 1 cycle, locked low same cycle, relock only after next two good vrises.
REQ-040 While locked, hsync held low -> locked drops when hper hits 1023 (1023 cycles after last hrise), no line_err.
REQ-041 While locked, one frame of 524 lines -> frame_err 1-cycle pulse, locked drops, py reloads 490 on that vrise.
REQ-042 rst_n low 1 cycle mid-frame while locked -> next cycle locked=0, px=0, py=0, state SEARCH.
